// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch/sequencing stage for the 16-bit core. Owns the program counter,
// reads one instruction word per fetch from a one-cycle-latency program
// memory, presents it to the core with `run` held high until `done`, resolves
// format-2 branches with `branch_res`, and stops on the halt word.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   begin fetching from current pc (IDLE/HALT only)
//   imem_req     out  1   program-memory read strobe (FETCH)
//   imem_addr    out  16  read address, always equal to pc
//   imem_rdata   in   16  read data, valid the cycle after imem_req
//   instruction  out  16  registered instruction word to the core
//   run          out  1   core may execute `instruction` (EXEC)
//   done         in   1   core finished current instruction (EXEC only)
//   branch_res   in   1   branch condition, sampled with `done`
//   pc           out  16  address of the instruction in flight
//   busy         out  1   FETCH, CAPTURE or EXEC
//   halted       out  1   HALT
//   retired      out  16  completed-instruction count, saturating
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic        run,
  input  logic        done,
  input  logic        branch_res,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;

  // Format-2 branch target: 8-bit two's complement offset from [12:5],
  // sign-extended; the 16-bit add wraps modulo 2^16 by construction.
  function automatic logic [15:0] branch_target(input logic [15:0] cur,
                                                input logic [7:0]  off);
    return cur + {{8{off[7]}}, off};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic is_taken_branch;
  assign is_taken_branch = (instr_q[1:0] == 2'd2) && branch_res;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The halt word is never issued: instruction and pc keep their
        // values so a later restart re-reads the same halt word.
        if (imem_rdata == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Leaving EXEC on the first done sample is what makes a held
        // done count exactly once.
        if (done) begin
          pc_d      = is_taken_branch ? branch_target(pc_q, instr_q[12:5])
                                      : pc_q + 16'd1;
          retired_d = sat_inc(retired_q);
          state_d   = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 16'h0000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Outputs come straight from registers or from a decode of the state
  // register, so done/branch_res never reach an output combinationally.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign run         = (state_q == S_EXEC);
  assign busy        = (state_q == S_FETCH) || (state_q == S_CAPTURE) ||
                       (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream fetch/sequencing stage for the 16-bit core. It owns the program counter and reads instruction words from program memory over a fixed one-cycle-latency port. Each word is presented to the core with `run` held high until the core reports `done`. It resolves format-2 branches with the core's `branch_res` flag and stops on a halt word.

## Interface

Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HALT_WORD`, 16'hFFFF, instruction encoding that stops fetching; it is never issued to the core.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins fetching from the current PC while in IDLE or HALT.
- `imem_req`  out  1  program-memory read strobe.
- `imem_addr`  out  16  read address; equals `pc` whenever `imem_req` is high.
- `imem_rdata`  in  16  read data; valid exactly one cycle after `imem_req`.
- `instruction`  out  16  instruction word to the core; registered.
- `run`  out  1  high while the core may execute `instruction`.
- `done`  in  1  core finished the current instruction; sampled only in EXEC.
- `branch_res`  in  1  branch condition from the core; sampled together with `done`.
- `pc`  out  16  address of the instruction currently in flight.
- `busy`  out  1  high in FETCH, CAPTURE and EXEC.
- `halted`  out  1  high in HALT.
- `retired`  out  16  count of completed instructions; saturates at 16'hFFFF.

## Operation

- **IDLE:** waits for `start`, then goes to FETCH.
- **FETCH (1 cycle):** `imem_req`=1 and `imem_addr`=`pc`, then goes to CAPTURE.
- **CAPTURE (1 cycle):** registers `imem_rdata` on the clock edge that ends this state.
  - If the word equals `HALT_WORD`, go to HALT; `instruction` keeps its previous value and `pc` is unchanged.
  - Otherwise load `instruction` with the word and go to EXEC.
- **EXEC:** `run`=1 and `instruction` is held stable. On the first cycle with `done`=1:
  - If `instruction[1:0]`==2 and `branch_res`=1: next pc = `pc` + sign-extended `instruction[12:5]` (8-bit two's complement).
  - Otherwise: next pc = `pc` + 1.
  - `retired` increments unless already 16'hFFFF.
  - Go to FETCH.
- **HALT:** `run`=0 and `halted`=1. `start` restarts at FETCH from the unchanged `pc`, which re-reads the halt word; software relocates by reset.
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 → 16'h0000, and 16'h0002 + (−4) → 16'hFFFE.
- A branch offset of 0 with `branch_res`=1 re-executes the same instruction.
- Format 2 with `branch_res`=0 falls through to pc+1.
- Formats 0, 1 and 3 ignore `branch_res`.
- `start` is ignored in FETCH, CAPTURE and EXEC.
- `done` is ignored outside EXEC.

## Timing

- Reset values: `pc`=`RESET_PC`, state=IDLE, `instruction`=16'h0000, `run`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `busy`=0, `halted`=0, `retired`=0.
- Reset asserted in any state forces all reset values immediately; no in-flight instruction completes and `retired` is not incremented.
- Outputs are registered or decoded from the state register only; there is no combinational path from `done` or `branch_res` to any output.
- Start-to-issue latency: `start` sampled at edge 0, `imem_req` high in cycle 1, `run` high from cycle 3.
- Minimum per-instruction period: 3 cycles (FETCH, CAPTURE, EXEC with `done` in its first cycle).
- `run` falls, and `pc`/`retired` update, in the cycle after the edge that samples `done`=1.
- `instruction` changes only on the CAPTURE→EXEC edge.
- `done` held high across multiple EXEC cycles counts once, because the state leaves EXEC after the first sample.

## Test plan

- **Sequential run:** reset, memory {0:16'h2405, 1:16'h4409, 2:16'hFFFF}, `start`, `done` one cycle after each `run` rise → instructions 16'h2405 then 16'h4409 issued, `halted`=1, `pc`=2, `retired`=2, `run` never high for 16'hFFFF.
- **Taken backward branch:** word at pc=5 is format 2 with `[12:5]`=8'hFE, `done`+`branch_res`=1 → next `imem_addr`=3.
- **Untaken branch and wrap:**
  - Same word with `branch_res`=0 → next fetch at 6.
  - A non-branch at pc=16'hFFFF → next fetch at 16'h0000.
- **Stall and spurious inputs:**
  - Hold `done`=0 for 10 EXEC cycles → `run` stays 1 and `instruction` is unchanged throughout.
  - `done` pulses in FETCH/CAPTURE and `start` pulses mid-run → no effect on `pc` or `retired`.
- **Reset mid-EXEC:** assert `reset` while `run`=1 → same cycle `run`=0, `pc`=`RESET_PC`, `retired`=0, state IDLE; a fresh `start` refetches from `RESET_PC`.
- **Saturation:** preload `retired` near the limit by forcing or running 65536 instructions → `retired` holds 16'hFFFF.
